dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port word-addressed data memory with a fixed number of wait states
// before each one-cycle response.
module dmem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept, enter_resp;

    logic        acc_we;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_err;
    logic [AW-1:0] acc_idx;

    logic [31:0] mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With zero wait states RESP is entered on the accept edge, before the
    // captured copies exist, so the live request fields are used then.
    always_comb begin
        acc_we    = (state_q == StIdle) ? req_we    : we_q;
        acc_addr  = (state_q == StIdle) ? req_addr  : addr_q;
        acc_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
        acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
        acc_idx   = acc_addr[AW+1:2];
        err_d     = acc_err;
        rdata_d   = (acc_we || acc_err) ? '0 : mem[acc_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Storage is not reset; a reset edge also cancels any pending commit.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, hand-written corner
// sequences and randomized accesses against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned W     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        v0 = 1'b0, we0 = 1'b0;
    logic [31:0] a0 = '0, d0 = '0;
    logic        ready0, rv0, er0, busy0;
    logic [31:0] rd0;

    int total = 0;
    int bad   = 0;

    logic [31:0] model   [DEPTH];
    bit          written [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(ready0),
        .req_we(we0), .req_addr(a0), .req_wdata(d0),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0), .busy(busy0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Called right after an edge with the DUT idle; returns once idle again.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] junk, output logic [31:0] rd, output logic er);
        int lat;
        bit seen;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        chk("ready_before", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = junk;
        seen = 0;
        lat  = 0;
        rd   = '0;
        er   = 1'b0;
        for (int n = 1; n <= 30 && !seen; n++) begin
            chk("busy_during", busy, 1);
            chk("ready_during", req_ready, 0);
            if (resp_valid) begin
                seen = 1;
                lat  = n;
                rd   = resp_rdata;
                er   = resp_err;
            end else begin
                chk("quiet_rdata", resp_rdata, 0);
                chk("quiet_err", resp_err, 0);
            end
            @(posedge clk); #1;
        end
        chk("latency", lat, 1 + W);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        logic        er;
        int          accepts, nresp, last;

        vecs.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0,        32'h11111111, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h13,       32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h400,      32'h12345678, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h3FC,      32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h3FC,      32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b0, 32'h0,        32'h0,        32'h11111111, 1'b0});
        vecs.push_back('{1'b1, 32'h2,        32'h00000002, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0,        32'h0,        32'h11111111, 1'b0});
        vecs.push_back('{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        rst = 1'b0;
        chk("rst_ready", req_ready, 1);
        chk("rst_ready0", ready0, 1);

        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, $urandom, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
        end

        // Back-to-back loads with req_valid held high
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        accepts = 0;
        nresp   = 0;
        last    = -1;
        for (int c = 0; c < 80 && nresp < 10; c++) begin
            if (resp_valid) begin
                if (last >= 0) chk("b2b_gap", c - last, 4);
                last = c;
                nresp++;
                chk("b2b_data", resp_rdata, 32'hDEADBEEF);
            end
            if (req_valid && req_ready) accepts++;
            @(posedge clk); #1;
            if (accepts == 10) req_valid = 1'b0;
        end
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) nresp++;
            @(posedge clk); #1;
        end
        chk("b2b_count", nresp, 10);

        // Store data changed while waiting is ignored
        access(1'b1, 32'h20, 32'h1, 32'h2, rd, er);
        access(1'b0, 32'h20, 32'h0, 32'h2, rd, er);
        chk("hold_wdata", rd, 32'h1);

        // Reset in the middle of WAIT abandons the store
        access(1'b1, 32'h8, 32'hAAAA5555, $urandom, rd, er);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h8;
        req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", req_ready, 1);
        nresp = 0;
        for (int c = 0; c < 5; c++) begin
            if (resp_valid) nresp++;
            @(posedge clk); #1;
        end
        chk("abort_no_resp", nresp, 0);
        access(1'b0, 32'h8, 32'h0, $urandom, rd, er);
        chk("abort_kept", rd, 32'hAAAA5555);

        // Zero wait states
        v0 = 1'b1; we0 = 1'b1; a0 = 32'h4; d0 = 32'h77;
        @(posedge clk); #1;
        v0 = 1'b0; d0 = 32'h0;
        chk("w0_resp_valid", rv0, 1);
        chk("w0_ready_resp", ready0, 0);
        chk("w0_store_rdata", rd0, 0);
        @(posedge clk); #1;
        chk("w0_ready_after", ready0, 1);
        chk("w0_quiet", rv0, 0);
        v0 = 1'b1; we0 = 1'b0;
        @(posedge clk); #1;
        v0 = 1'b0;
        chk("w0_load_valid", rv0, 1);
        chk("w0_load_data", rd0, 32'h77);
        chk("w0_load_err", er0, 0);
        @(posedge clk); #1;

        // Randomized accesses against the reference model
        for (int i = 0; i < 150; i++) begin
            int unsigned r;
            logic        we;
            logic [31:0] a, wd;
            logic        exp_err;
            r  = $urandom_range(0, 9);
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (r == 0)      a = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
            else if (r == 1) a = $urandom | 32'h400;
            else             a = $urandom_range(0, 255) << 2;
            exp_err = (a % 4 != 0) || (longint'(a) >= longint'(4 * DEPTH));
            access(we, a, wd, $urandom, rd, er);
            chk("rnd_err", er, exp_err);
            if (we || exp_err) chk("rnd_rdata_zero", rd, 0);
            else if (written[a / 4]) chk("rnd_load", rd, model[a / 4]);
            if (we && !exp_err) begin
                model[a / 4]   = wd;
                written[a / 4] = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
